// File: rtl/downsampler_4_pkg.sv
// Shared constants for the 4x receive decimator: phase counter geometry,
// timing-adjust FSM encodings and 18-bit saturation limits.
package downsampler_4_pkg;

  localparam int OSR   = 4;
  localparam int CNT_W = 2;

  localparam logic [CNT_W-1:0] SKIP_PHASE = CNT_W'(OSR - 2);
  localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(OSR - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADV_PEND = 2'd1,
    RET_PEND = 2'd2,
    RET_HOLD = 2'd3
  } adj_state_e;

  localparam logic signed [17:0] SAT_MAX_18 = 18'sh1FFFF;
  localparam logic signed [17:0] SAT_MIN_18 = 18'sh20000;

endpackage

// File: rtl/downsampler_4_timing_adj_fsm.sv
// Latches one advance/retard request at a time and tells the phase counter
// when to skip ahead (3-sample period) or hold at the last phase (5-sample period).
module downsampler_4_timing_adj_fsm
  import downsampler_4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             sam_clk_en,
  input  logic             sym_sync,
  input  logic             adv_req,
  input  logic             ret_req,
  input  logic [CNT_W-1:0] count_4,
  output logic             skip,
  output logic             hold,
  output logic             adj_busy
);

  adj_state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Decisions use the registered state, so a request landing on the decision
  // point itself only arms the FSM and takes effect one period later.
  always_comb begin
    state_d = state_q;
    skip    = 1'b0;
    hold    = 1'b0;
    if (sym_sync) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (adv_req && !ret_req)      state_d = ADV_PEND;
          else if (ret_req && !adv_req) state_d = RET_PEND;
        end
        ADV_PEND: begin
          if (sam_clk_en && count_4 == SKIP_PHASE) begin
            skip    = 1'b1;
            state_d = IDLE;
          end
        end
        RET_PEND: begin
          if (sam_clk_en && count_4 == LAST_PHASE) begin
            hold    = 1'b1;
            state_d = RET_HOLD;
          end
        end
        RET_HOLD: begin
          if (sam_clk_en) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign adj_busy = (state_q != IDLE);

endmodule

// File: rtl/downsampler_4.sv
// Decimates 4x-oversampled matched-filter output to symbol rate with a trackable phase.
// Define DOWNSAMPLER_ACCUM_EN for integrate-and-dump instead of a single-sample pick.
module downsampler_4
  import downsampler_4_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int INIT_PHASE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sam_clk_en,
  input  logic                    sym_sync,
  input  logic                    adv_req,
  input  logic                    ret_req,
  input  logic signed [WIDTH-1:0] data_in,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    sym_clk_en_out,
  output logic                    adj_busy,
  output logic [CNT_W-1:0]        count_4
);

  logic skip;
  logic hold;
  logic capture;
  logic signed [WIDTH-1:0] cap_val;

  downsampler_4_timing_adj_fsm u_adj (
    .clk        (clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .sym_sync   (sym_sync),
    .adv_req    (adv_req),
    .ret_req    (ret_req),
    .count_4    (count_4),
    .skip       (skip),
    .hold       (hold),
    .adj_busy   (adj_busy)
  );

  assign capture = sam_clk_en && !sym_sync && (count_4 == '0);

  // Hold keeps the phase at its last value for one extra sample; the natural
  // wrap on the following sample then closes the 5-sample period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_4 <= CNT_W'(INIT_PHASE);
    end else if (sym_sync) begin
      count_4 <= '0;
    end else if (sam_clk_en) begin
      if (skip)      count_4 <= '0;
      else if (hold) count_4 <= count_4;
      else           count_4 <= count_4 + 1'b1;
    end
  end

`ifdef DOWNSAMPLER_ACCUM_EN
  localparam int AW = WIDTH + 3;
  localparam logic signed [AW-1:0] SAT_HI = {4'b0000, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {4'b1111, {(WIDTH-1){1'b0}}};

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_shr;
  logic signed [AW-1:0] din_ext;

  assign din_ext = {{3{data_in[WIDTH-1]}}, data_in};
  assign acc_shr = acc >>> 2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (sym_sync) begin
      acc <= '0;
    end else if (sam_clk_en) begin
      acc <= (count_4 == '0) ? din_ext : acc + din_ext;
    end
  end

  // Fixed /4 scaling regardless of period length, so 5-sample periods can overrange.
  always_comb begin
    cap_val = acc_shr[WIDTH-1:0];
    if (acc_shr > SAT_HI)      cap_val = SAT_HI[WIDTH-1:0];
    else if (acc_shr < SAT_LO) cap_val = SAT_LO[WIDTH-1:0];
  end
`else
  assign cap_val = data_in;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out       <= '0;
      sym_clk_en_out <= 1'b0;
    end else begin
      sym_clk_en_out <= capture;
      if (capture) data_out <= cap_val;
    end
  end

endmodule

// File: tb/tb_downsampler_4.sv
// Randomized and directed stimulus for downsampler_4 against a period-length reference model.
// Builds with or without DOWNSAMPLER_ACCUM_EN; directed capture lists follow the active mode.
module tb_downsampler_4;

  localparam int W = 18;

  logic clk = 1'b0;
  logic reset;
  logic sam_clk_en, sym_sync, adv_req, ret_req;
  logic signed [W-1:0] data_in;
  logic signed [W-1:0] data_out;
  logic sym_clk_en_out, adj_busy;
  logic [1:0] count_4;

  always #5 clk = ~clk;

  downsampler_4 #(.WIDTH(W), .INIT_PHASE(0)) dut (
    .clk            (clk),
    .reset          (reset),
    .sam_clk_en     (sam_clk_en),
    .sym_sync       (sym_sync),
    .adv_req        (adv_req),
    .ret_req        (ret_req),
    .data_in        (data_in),
    .data_out       (data_out),
    .sym_clk_en_out (sym_clk_en_out),
    .adj_busy       (adj_busy),
    .count_4        (count_4)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: position within the current symbol period and that period's length.
  int m_p, m_len, m_pend, m_sum, m_dout;
  bit m_stb;
  int cap_q[$];

  task automatic chk_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_shr(input int s);
    int v;
    v = s >>> 2;
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  task automatic model_reset();
    m_p = 0; m_len = 4; m_pend = 0; m_sum = 0; m_dout = 0; m_stb = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk_eq({tag, ".cnt"}, count_4, (m_p > 3) ? 3 : m_p);
    chk_eq({tag, ".busy"}, adj_busy, (m_pend != 0) ? 1 : 0);
    chk_eq({tag, ".stb"}, sym_clk_en_out, m_stb);
    chk_eq({tag, ".dout"}, data_out, m_dout);
  endtask

  task automatic step(input bit en, input bit sync, input bit adv, input bit ret, input int din);
    logic signed [W-1:0] d18;
    int ds, old;
    d18 = din[W-1:0];
    ds  = d18;
    @(negedge clk);
    sam_clk_en = en; sym_sync = sync; adv_req = adv; ret_req = ret; data_in = d18;
    @(posedge clk);
    m_stb = 0;
    if (sync) begin
      m_p = 0; m_len = 4; m_pend = 0; m_sum = 0;
    end else begin
      old = m_pend;
      if (en) begin
        if (m_p == 0) begin
`ifdef DOWNSAMPLER_ACCUM_EN
          m_dout = sat_shr(m_sum);
`else
          m_dout = ds;
`endif
          m_sum = ds;
          m_stb = 1;
        end else begin
          m_sum += ds;
        end
        if (old == 1 && m_p == 2) begin m_len = 3; m_pend = 0; end
        if (old == 2 && m_p == 3) m_len = 5;
        if (old == 2 && m_p == 4) m_pend = 0;
        m_p++;
        if (m_p >= m_len) begin m_p = 0; m_len = 4; end
      end
      if (old == 0 && (adv != ret)) m_pend = adv ? 1 : 2;
    end
    #1;
    check_outputs("step");
    if (m_stb) cap_q.push_back(m_dout);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    sam_clk_en = 0; sym_sync = 0; adv_req = 0; ret_req = 0; data_in = '0;
    #1;
    model_reset();
    check_outputs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One sample every 4th clk, with optional request pulses after sample k.
  task automatic ramp(input int n, input int adv_k, input int ret_k, input int ret2_k, input int both_k);
    step(0, 1, 0, 0, 0);
    cap_q.delete();
    for (int k = 1; k <= n; k++) begin
      step(1, 0, 0, 0, k);
      step(0, 0, (k == adv_k) || (k == both_k), (k == ret_k) || (k == ret2_k) || (k == both_k), 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic check_caps(input string tag, input int n, input int a, input int b, input int c, input int d);
    int e[4];
    e = '{a, b, c, d};
    chk_eq({tag, ".ncap"}, cap_q.size(), n);
    if (cap_q.size() >= n)
      for (int i = 0; i < n; i++) chk_eq({tag, ".cap"}, cap_q[i], e[i]);
  endtask

  initial begin
    reset = 1'b1;
    sam_clk_en = 0; sym_sync = 0; adv_req = 0; ret_req = 0; data_in = '0;
    do_reset();
    chk_eq("rst.cnt0", count_4, 0);
    chk_eq("rst.dout0", data_out, 0);

    ramp(16, 0, 0, 0, 0);
`ifndef DOWNSAMPLER_ACCUM_EN
    check_caps("nominal", 4, 1, 5, 9, 13);
`endif
    ramp(14, 5, 0, 0, 0);
`ifndef DOWNSAMPLER_ACCUM_EN
    check_caps("adv", 4, 1, 5, 8, 12);
`endif
    ramp(16, 0, 5, 6, 0);
`ifndef DOWNSAMPLER_ACCUM_EN
    check_caps("ret", 4, 1, 5, 10, 14);
`endif
    ramp(12, 0, 0, 0, 2);
`ifndef DOWNSAMPLER_ACCUM_EN
    check_caps("both", 3, 1, 5, 9, 0);
`endif

    // Re-align at count 2 while an advance is pending.
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    chk_eq("sync.armed", adj_busy, 1);
    step(1, 0, 0, 0, 2);
    step(1, 1, 0, 0, 3);
    chk_eq("sync.cnt", count_4, 0);
    chk_eq("sync.busy", adj_busy, 0);
    step(0, 0, 0, 0, 0);
    chk_eq("sync.nostb", sym_clk_en_out, 0);
    step(1, 0, 0, 0, 4);
    chk_eq("sync.stb", sym_clk_en_out, 1);
`ifndef DOWNSAMPLER_ACCUM_EN
    chk_eq("sync.dout", data_out, 4);
`endif

    // Reset while a retard is pending drops it.
    step(0, 0, 0, 1, 0);
    do_reset();
    chk_eq("rstadj.busy", adj_busy, 0);

`ifdef DOWNSAMPLER_ACCUM_EN
    step(0, 1, 0, 0, 0);
    repeat (12) step(1, 0, 0, 0, 131071);
    chk_eq("acc.max", cap_q[cap_q.size()-1], 131071);
    step(0, 0, 0, 1, 0);
    repeat (8) step(1, 0, 0, 0, 131071);
    chk_eq("acc.sat5", cap_q[cap_q.size()-1], 131071);
    repeat (12) step(1, 0, 0, 0, -131072);
    chk_eq("acc.min", cap_q[cap_q.size()-1], -131072);
`endif

    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) do_reset();
      step($urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, int'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
